// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated stream multiplexer.
package arb_mux_pkg;

  // Arbitration policy selected at elaboration time.
  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  // Packet-lock state: open for arbitration, or held by one channel mid-packet.
  typedef enum logic {
    LK_OPEN,
    LK_HELD
  } lock_state_e;

  // Channel-index width; a single channel still needs a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational channel picker: rotate the search start to ptr (round-robin)
// or to 0 (fixed priority) and return the first requesting channel.
module arb_pick
  import arb_mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  localparam int unsigned NU = N;

  int unsigned base;
  int unsigned idx;

  // Walk channels from the start position, wrapping modulo N; first hit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    base    = (MODE == ARB_RR) ? 32'(ptr) : 32'd0;
    idx     = 32'd0;
    if (base >= NU) begin
      base = 32'd0;
    end
    for (int unsigned k = 0; k < NU; k++) begin
      idx = base + k;
      if (idx >= NU) begin
        idx = idx - NU;
      end
      if (!gnt_any && req[SELW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel registered stream multiplexer with internal arbitration and
// packet locking on last-delimited multi-beat transfers.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  lock_state_e       state;
  lock_state_e       state_nxt;
  logic [SELW-1:0]   locked_ch;
  logic [SELW-1:0]   locked_ch_nxt;
  logic [SELW-1:0]   ptr;
  logic [SELW-1:0]   ptr_nxt;
  logic [SELW:0]     ptr_inc;

  logic [SELW-1:0]   pick_idx;
  logic              pick_any;
  logic [SELW-1:0]   gnt;
  logic              grant_valid;
  logic              load;
  logic              accept;

  logic [WIDTH-1:0]  ch_data [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  arb_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // While a packet is in flight the owner keeps the grant, even if it idles.
  always_comb begin
    if (state == LK_HELD) begin
      gnt         = locked_ch;
      grant_valid = in_valid[locked_ch];
    end else begin
      gnt         = pick_idx;
      grant_valid = pick_any;
    end
  end

  // Output register can take a beat when empty or draining this cycle.
  always_comb begin
    load     = !out_valid || out_ready;
    accept   = load && grant_valid;
    in_ready = '0;
    if (accept) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // Lock and pointer next-state; pointer advances only at packet boundaries.
  always_comb begin
    state_nxt     = state;
    locked_ch_nxt = locked_ch;
    ptr_nxt       = ptr;
    ptr_inc       = {1'b0, gnt} + 1'b1;
    if (accept) begin
      if (in_last[gnt]) begin
        state_nxt = LK_OPEN;
        ptr_nxt   = (ptr_inc >= (SELW+1)'(N)) ? '0 : ptr_inc[SELW-1:0];
      end else begin
        state_nxt     = LK_HELD;
        locked_ch_nxt = gnt;
      end
    end
  end

  // Lock/pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LK_OPEN;
      locked_ch <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      locked_ch <= locked_ch_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // Single output stage; payload only changes when a new beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= ch_data[gnt];
        out_last <= in_last[gnt];
        out_sel  <= gnt;
      end
    end
  end

  // At most one channel is accepted, and only one that is offering a beat.
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));
  a_ready_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready & ~in_valid) == '0);

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: round-robin and fixed-priority instances share inputs and
// are each compared against a packet-level reference model every cycle.
module tb_arb_mux;
  import arb_mux_pkg::*;

  localparam int W  = 32;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]   in_v;
  logic [NC-1:0]   in_l;
  logic [W-1:0]    in_d [NC];
  logic [NC*W-1:0] in_flat;
  logic            out_ready;

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign in_flat[g*W +: W] = in_d[g];
  end

  logic [NC-1:0] rdy [2];
  logic          ov  [2];
  logic [W-1:0]  od  [2];
  logic          ol  [2];
  logic [1:0]    os  [2];

  arb_mux #(.WIDTH(W), .N(NC), .MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v), .in_data(in_flat),
    .in_last(in_l), .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_last(ol[0]), .out_sel(os[0]), .out_ready(out_ready));

  arb_mux #(.WIDTH(W), .N(NC), .MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_v), .in_data(in_flat),
    .in_last(in_l), .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_last(ol[1]), .out_sel(os[1]), .out_ready(out_ready));

  int n_checks = 0;
  int n_errors = 0;
  string names [2] = '{"rr", "fx"};

  // Reference model per instance: output register, packet owner, next priority.
  int         m_ov    [2];
  logic [W-1:0] m_od  [2];
  int         m_ol    [2];
  int         m_os    [2];
  int         m_owner [2];
  int         m_next  [2];
  logic [NC-1:0] last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_od[d] = '0; m_ol[d] = 0; m_os[d] = 0;
      m_owner[d] = -1; m_next[d] = 0;
    end
    last_acc = '0;
  endfunction

  function automatic int winner(int d);
    int base;
    int c;
    if (m_owner[d] >= 0) return in_v[m_owner[d]] ? m_owner[d] : -1;
    base = (d == 0) ? m_next[d] : 0;
    for (int k = 0; k < NC; k++) begin
      c = (base + k) % NC;
      if (in_v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance model, check outputs after.
  task automatic step();
    int w [2];
    bit ld [2];
    logic [NC-1:0] exp_rdy;
    #1;
    for (int d = 0; d < 2; d++) begin
      ld[d] = (m_ov[d] == 0) || out_ready;
      w[d]  = winner(d);
      exp_rdy = '0;
      if (ld[d] && w[d] >= 0) exp_rdy[w[d]] = 1'b1;
      check({names[d], ".in_ready"}, 64'(rdy[d]), 64'(exp_rdy));
      if (d == 0) last_acc = exp_rdy;
      if (ld[d]) begin
        if (w[d] >= 0) begin
          m_ov[d] = 1; m_od[d] = in_d[w[d]]; m_ol[d] = int'(in_l[w[d]]); m_os[d] = w[d];
          if (in_l[w[d]]) begin
            m_owner[d] = -1;
            m_next[d]  = (w[d] + 1) % NC;
          end else begin
            m_owner[d] = w[d];
          end
        end else begin
          m_ov[d] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check({names[d], ".out_valid"}, 64'(ov[d]), 64'(m_ov[d]));
      if (m_ov[d] != 0) begin
        check({names[d], ".out_data"}, 64'(od[d]), 64'(m_od[d]));
        check({names[d], ".out_last"}, 64'(ol[d]), 64'(m_ol[d]));
        check({names[d], ".out_sel"},  64'(os[d]), 64'(m_os[d]));
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check({names[d], ".rst_valid"}, 64'(ov[d]), 64'd0);
      check({names[d], ".rst_data"},  64'(od[d]), 64'd0);
      check({names[d], ".rst_last"},  64'(ol[d]), 64'd0);
      check({names[d], ".rst_sel"},   64'(os[d]), 64'd0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void set_ch(int c, bit v, logic [W-1:0] dat, bit lst);
    in_v[c] = v; in_d[c] = dat; in_l[c] = lst;
  endfunction

  initial begin
    in_v = '0; in_l = '1; out_ready = 1'b1;
    for (int c = 0; c < NC; c++) in_d[c] = '0;
    model_reset();
    do_reset();

    // Round-robin rotation with every channel offering single-beat packets.
    for (int c = 0; c < NC; c++) set_ch(c, 1'b1, 32'hA0 + 32'(c), 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_rotate_sel", 64'(os[0]), 64'(k % NC));
      check("rr_rotate_data", 64'(od[0]), 64'(32'hA0 + 32'(k % NC)));
      check("fx_fixed_sel0", 64'(os[1]), 64'd0);
    end

    // Three-beat packet on ch2 keeps the grant while ch0 waits.
    in_v = '0;
    set_ch(0, 1'b1, 32'h0000_00F0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_ch(2, 1'b1, 32'hC0 + 32'(k), k == 2);
      step();
      check("rr_lock_sel", 64'(os[0]), 64'd2);
    end
    in_v[2] = 1'b0;
    step();
    check("rr_after_pkt_sel", 64'(os[0]), 64'd0);

    // Fixed priority: ch1 always beats ch3.
    in_v = '0;
    set_ch(1, 1'b1, 32'h11, 1'b1);
    set_ch(3, 1'b1, 32'h33, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("fx_prio_sel", 64'(os[1]), 64'd1);
      check("fx_ch3_ready", 64'(rdy[1][3]), 64'd0);
    end

    // Backpressure: held beat stays put, then retire+accept in one cycle.
    in_v = '0;
    set_ch(1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step();
    check("bp_first", 64'(od[0]), 64'hDEAD_BEEF);
    out_ready = 1'b0;
    in_d[1] = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_data", 64'(od[0]), 64'hDEAD_BEEF);
      check("bp_ready_zero", 64'(rdy[0]), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_swap_valid", 64'(ov[0]), 64'd1);
    check("bp_swap_data", 64'(od[0]), 64'h1234_5678);
    in_v = '0;
    step();
    check("bp_drain_valid", 64'(ov[0]), 64'd0);

    // Locked owner goes idle mid-packet: nobody else is served.
    set_ch(1, 1'b1, 32'h111, 1'b0);
    step();
    in_v[1] = 1'b0;
    set_ch(3, 1'b1, 32'h333, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      check("gap_ready", 64'(rdy[0]), 64'd0);
      check("gap_valid", 64'(ov[0]), 64'd0);
    end
    set_ch(1, 1'b1, 32'h112, 1'b1);
    step();
    check("gap_resume_sel", 64'(os[0]), 64'd1);
    check("gap_resume_data", 64'(od[0]), 64'h112);
    in_v[1] = 1'b0;
    step();
    check("gap_then_ch3", 64'(os[0]), 64'd3);

    // Reset while ch2 holds the lock; ch0 must win afterwards.
    in_v = '0;
    set_ch(2, 1'b1, 32'h222, 1'b0);
    step();
    set_ch(2, 1'b1, 32'h223, 1'b1);
    set_ch(0, 1'b1, 32'h1000, 1'b1);
    do_reset();
    step();
    check("rst_unlock_sel", 64'(os[0]), 64'd0);
    check("rst_unlock_data", 64'(od[0]), 64'h1000);

    // Randomised traffic, sources hold beats until accepted by the rr instance.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      for (int c = 0; c < NC; c++) begin
        if (!(in_v[c] && !last_acc[c])) begin
          in_v[c] = ($urandom_range(0, 99) < 60);
          in_d[c] = $urandom;
          in_l[c] = ($urandom_range(0, 2) == 0);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
